alu_sequencer: RTL and testbench
================================

# alu_sequencer

Multi-cycle control sequencer that drives the combinational ALU from the instruction side. It accepts 9-bit instructions over a valid/ready handshake and decodes them into ALU opcode fields and register-file addresses. It latches the ALU's status outputs into an architectural flag register and runs the data-memory request/acknowledge handshake for LOAD/STORE. It sits between instruction fetch and the ALU/register-file datapath.

## Interface
- `MEM_TIMEOUT`, 16: cycles a memory request may wait for `mem_ack` before abort (only with watchdog compiled in).
- Clock and reset: one clock, `Clk`; reset `Reset` is synchronous and active-high.
- `Clk` in 1: clock.
- `Reset` in 1: synchronous, active-high reset.
- `instr_valid` in 1: instruction presented.
- `instr` in 9: instruction word.
- `instr_ready` out 1: sequencer can accept.
- `rf_addr_a` out 3: register-file read port A (destination/first operand).
- `rf_addr_b` out 3: register-file read port B (second operand / memory address).
- `rf_wr_en` out 1: register-file write strobe.
- `rf_wr_addr` out 3: write address.
- `wb_sel` out 1: 0 = write ALU_out, 1 = write mem_rdata (external mux).
- `ALU_op_code` out 3: to ALU.
- `Data_op_code` out 2: to ALU.
- `Data_signifier` out 1: to ALU.
- `SC_IN` out 1: carry-in to ALU, equal to flag C.
- `ZERO`, `BEVEN`, `PARITY`, `EQUAL`, `SC_OUT` in 1 each: ALU status.
- `mem_req` out 1: memory request.
- `mem_we` out 1: 1 = store.
- `mem_ack` in 1: memory done.
- `flags` out 5: {C, Z, E(beven), P, Q(equal)}.
- `busy` out 1: not IDLE.
- `mem_err` out 1: sticky watchdog abort (watchdog builds only; otherwise tied 0).

## Operation
- Decode: `instr[8]` drives `Data_signifier`.
  - Arithmetic (bit8 = 0): op = [7:5]; rd = {1'b0, [4:3]}; rs = [2:0].
  - Data (bit8 = 1): op = [7:6]; rd = [5:3]; rs = [2:0].
  - `rf_addr_a` = rd, `rf_addr_b` = rs.
- Encodings (package `definitions`): kADD 0, kLSL 1, kXOR 2, kAND 3, kCMP 4, kSET 5, kLSR 6, kSUB 7; kMOVE 0, kFLAG 1, kLOAD 2, kSTORE 3.
- States:
  - IDLE: `instr_ready` = 1. `instr_valid` & ready latches `instr` and moves to EXEC.
  - EXEC: decoded fields are driven from the latched word.
    - Arithmetic except kCMP: `rf_wr_en` = 1, `wb_sel` = 0, `rf_wr_addr` = rd; flags load from the ALU; go to IDLE.
    - kCMP: no write; flags load; go to IDLE.
    - kMOVE: write, flags unchanged; go to IDLE.
    - kFLAG: write, flags load; go to IDLE.
    - kLOAD/kSTORE: go to MEM.
  - MEM: `mem_req` = 1, `mem_we` = (op == kSTORE); hold until `mem_ack`.
    - On ack, LOAD asserts `rf_wr_en` with `wb_sel` = 1 in the same cycle.
    - Return to IDLE.
- Flag load = {SC_OUT, ZERO, BEVEN, PARITY, EQUAL}, sampled at the EXEC clock edge.
- All decoded outputs are 0 in IDLE. `rf_wr_en` is 0 except as stated above.

## Timing
- Reset values: `instr_ready` 1, `flags` 0, `mem_err` 0; all other outputs 0; state IDLE.
- Arithmetic/data ops: 2 cycles accept-to-accept. Write and flag update occur at the edge ending EXEC.
- LOAD/STORE: 2 + N cycles, where N ≥ 1 is the number of MEM cycles up to and including the ack.
- `instr_valid` while not ready is ignored; the instruction is not consumed. `mem_ack` outside MEM is ignored.
- `mem_ack` in the first MEM cycle completes that cycle, so the minimum load is 3 cycles.
- `Reset` high at any edge, including mid-MEM, forces IDLE and reset values at that edge. `Reset` dominates `instr_valid` and `mem_ack`.

## Configuration
- `ALU_SEQ_WATCHDOG_EN` defined:
  - A counter clears on MEM entry and increments each MEM cycle without ack.
  - On reaching `MEM_TIMEOUT`: drop `mem_req`, no register write, set sticky `mem_err`, return to IDLE.
  - `mem_err` clears only on `Reset`.
- Undefined: no counter; MEM waits indefinitely; `mem_err` tied 0.

## Structure
- Package `definitions` holds:
  - the existing opcode enums;
  - new `seq_state_t` {IDLE, EXEC, MEM};
  - flag bit-index constants.
- One sub-module, `instr_decode`: purely combinational field extraction from `instr`.
- Sequencer FSM, flag register and watchdog live in the top block.

## Test plan
- Reset, then `instr` = 9'b0_000_01_010 (ADD R1,R2) with ALU ZERO = 1 → in EXEC: `rf_wr_en` = 1, `rf_wr_addr` = 1, `rf_addr_b` = 2; then `flags` = 5'b01000; `instr_ready` back to 1 on the next cycle.
- kCMP with EQUAL = 1 → no `rf_wr_en` pulse; `flags[0]` = 1; kMOVE next leaves `flags` unchanged.
- LOAD rd=5, rs=3 with `mem_ack` delayed 4 cycles → `mem_req` high 4 cycles, `mem_we` = 0; write to R5 with `wb_sel` = 1 on the ack cycle; total 6 cycles.
- STORE with `mem_ack` in the first MEM cycle → `mem_we` = 1 for 1 cycle; no register write.
- `Reset` during the 2nd MEM cycle → next cycle `mem_req` = 0, `flags` = 0, `instr_ready` = 1; a late `mem_ack` is ignored.
- Watchdog build, `MEM_TIMEOUT` = 4, no ack → `mem_req` drops after 4 cycles; `mem_err` = 1 and stays set until `Reset`.

Source files
------------

// File: rtl/alu_sequencer_pkg.sv
// Shared types for the ALU control sequencer: opcode encodings, sequencer states, flag bit positions.
// The watchdog option is compiled in with ALU_SEQ_WATCHDOG_EN; nothing in this package depends on it.
package definitions;

    localparam int INSTR_W = 9;
    localparam int FLAG_W  = 5;

    typedef enum logic [2:0] {
        kADD = 3'd0,
        kLSL = 3'd1,
        kXOR = 3'd2,
        kAND = 3'd3,
        kCMP = 3'd4,
        kSET = 3'd5,
        kLSR = 3'd6,
        kSUB = 3'd7
    } op_code_t;

    typedef enum logic [1:0] {
        kMOVE  = 2'd0,
        kFLAG  = 2'd1,
        kLOAD  = 2'd2,
        kSTORE = 2'd3
    } data_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MEM  = 2'd2
    } seq_state_t;

    // Positions inside the architectural flag word {C, Z, E, P, Q}.
    localparam int FLAG_C = 4;
    localparam int FLAG_Z = 3;
    localparam int FLAG_E = 2;
    localparam int FLAG_P = 1;
    localparam int FLAG_Q = 0;

    function automatic logic [FLAG_W-1:0] pack_flags(
        input logic sc_out,
        input logic zero,
        input logic beven,
        input logic parity,
        input logic equal
    );
        logic [FLAG_W-1:0] f;
        f         = '0;
        f[FLAG_C] = sc_out;
        f[FLAG_Z] = zero;
        f[FLAG_E] = beven;
        f[FLAG_P] = parity;
        f[FLAG_Q] = equal;
        return f;
    endfunction

endpackage

// File: rtl/alu_sequencer_instr_decode.sv
// Combinational field extraction and operation classification for one 9-bit instruction word.
// Independent of the ALU_SEQ_WATCHDOG_EN build option.
module instr_decode
    import definitions::*;
(
    input  logic [INSTR_W-1:0] instr_i,
    output logic               data_sig_o,
    output logic [2:0]         alu_op_o,
    output logic [1:0]         data_op_o,
    output logic [2:0]         rd_o,
    output logic [2:0]         rs_o,
    output logic               is_reg_write_o,
    output logic               is_flag_load_o,
    output logic               is_mem_o,
    output logic               is_store_o
);

    always_comb begin
        data_sig_o     = instr_i[8];
        alu_op_o       = '0;
        data_op_o      = '0;
        rd_o           = '0;
        rs_o           = instr_i[2:0];
        is_reg_write_o = 1'b0;
        is_flag_load_o = 1'b0;
        is_mem_o       = 1'b0;
        is_store_o     = 1'b0;

        if (instr_i[8]) begin
            data_op_o      = instr_i[7:6];
            rd_o           = instr_i[5:3];
            // MOVE and FLAG write back from the ALU; LOAD writes later, from memory.
            is_reg_write_o = (instr_i[7:6] == kMOVE) || (instr_i[7:6] == kFLAG);
            is_flag_load_o = (instr_i[7:6] == kFLAG);
            is_mem_o       = (instr_i[7:6] == kLOAD) || (instr_i[7:6] == kSTORE);
            is_store_o     = (instr_i[7:6] == kSTORE);
        end else begin
            alu_op_o       = instr_i[7:5];
            rd_o           = {1'b0, instr_i[4:3]};
            is_reg_write_o = (instr_i[7:5] != kCMP);
            is_flag_load_o = 1'b1;
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Instruction-side sequencer for the ALU datapath: IDLE -> EXEC -> (MEM) -> IDLE, flag register, memory handshake.
// Define ALU_SEQ_WATCHDOG_EN to add the MEM_TIMEOUT memory watchdog and the sticky mem_err flag.
module alu_sequencer
    import definitions::*;
#(
    parameter int MEM_TIMEOUT = 16
)
(
    input  logic               Clk,
    input  logic               Reset,
    input  logic               instr_valid,
    input  logic [INSTR_W-1:0] instr,
    output logic               instr_ready,
    output logic [2:0]         rf_addr_a,
    output logic [2:0]         rf_addr_b,
    output logic               rf_wr_en,
    output logic [2:0]         rf_wr_addr,
    output logic               wb_sel,
    output logic [2:0]         ALU_op_code,
    output logic [1:0]         Data_op_code,
    output logic               Data_signifier,
    output logic               SC_IN,
    input  logic               ZERO,
    input  logic               BEVEN,
    input  logic               PARITY,
    input  logic               EQUAL,
    input  logic               SC_OUT,
    output logic               mem_req,
    output logic               mem_we,
    input  logic               mem_ack,
    output logic [FLAG_W-1:0]  flags,
    output logic               busy,
    output logic               mem_err,
    output logic [1:0]         dbg_state_o
);

    // Handshake: an instruction transfers on a rising edge where instr_valid and
    // instr_ready are both 1; instr_ready is 1 exactly when the sequencer is IDLE,
    // and instr_valid in any other state is ignored without consuming the word.

    seq_state_t          state_q, state_d;
    logic [INSTR_W-1:0]  instr_q, instr_d;
    logic [FLAG_W-1:0]   flags_q, flags_d;
    logic                mem_err_q, mem_err_d;

    logic                dec_data_sig;
    logic [2:0]          dec_alu_op;
    logic [1:0]          dec_data_op;
    logic [2:0]          dec_rd;
    logic [2:0]          dec_rs;
    logic                dec_reg_write;
    logic                dec_flag_load;
    logic                dec_mem;
    logic                dec_store;
    logic [FLAG_W-1:0]   alu_status;

`ifdef ALU_SEQ_WATCHDOG_EN
    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);
    logic [CNT_W-1:0]    wd_cnt_q, wd_cnt_d;
`endif

    instr_decode u_decode (
        .instr_i        (instr_q),
        .data_sig_o     (dec_data_sig),
        .alu_op_o       (dec_alu_op),
        .data_op_o      (dec_data_op),
        .rd_o           (dec_rd),
        .rs_o           (dec_rs),
        .is_reg_write_o (dec_reg_write),
        .is_flag_load_o (dec_flag_load),
        .is_mem_o       (dec_mem),
        .is_store_o     (dec_store)
    );

    assign alu_status = pack_flags(SC_OUT, ZERO, BEVEN, PARITY, EQUAL);

    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        flags_d   = flags_q;
        mem_err_d = mem_err_q;
`ifdef ALU_SEQ_WATCHDOG_EN
        wd_cnt_d  = wd_cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (instr_valid) begin
                    instr_d = instr;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (dec_flag_load) begin
                    flags_d = alu_status;
                end
                if (dec_mem) begin
                    state_d = MEM;
`ifdef ALU_SEQ_WATCHDOG_EN
                    wd_cnt_d = '0;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            MEM: begin
                if (mem_ack) begin
                    state_d = IDLE;
                end
`ifdef ALU_SEQ_WATCHDOG_EN
                // An ack in the last allowed cycle still completes normally.
                else if (wd_cnt_q == CNT_LAST) begin
                    state_d   = IDLE;
                    mem_err_d = 1'b1;
                end else begin
                    wd_cnt_d = wd_cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            instr_q   <= '0;
            flags_q   <= '0;
            mem_err_q <= 1'b0;
`ifdef ALU_SEQ_WATCHDOG_EN
            wd_cnt_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            flags_q   <= flags_d;
            mem_err_q <= mem_err_d;
`ifdef ALU_SEQ_WATCHDOG_EN
            wd_cnt_q  <= wd_cnt_d;
`endif
        end
    end

    logic active;
    logic in_exec;
    logic in_mem;
    logic load_done;

    assign active    = (state_q != IDLE);
    assign in_exec   = (state_q == EXEC);
    assign in_mem    = (state_q == MEM);
    assign load_done = in_mem && !dec_store && mem_ack;

    // Decoded fields are held at zero while IDLE so the datapath sees no stale operation.
    always_comb begin
        instr_ready    = !active;
        busy           = active;
        Data_signifier = active ? dec_data_sig : 1'b0;
        ALU_op_code    = active ? dec_alu_op   : 3'd0;
        Data_op_code   = active ? dec_data_op  : 2'd0;
        rf_addr_a      = active ? dec_rd       : 3'd0;
        rf_addr_b      = active ? dec_rs       : 3'd0;
        rf_wr_addr     = active ? dec_rd       : 3'd0;
        rf_wr_en       = (in_exec && dec_reg_write) || load_done;
        wb_sel         = load_done;
        mem_req        = in_mem;
        mem_we         = in_mem && dec_store;
        SC_IN          = flags_q[FLAG_C];
        flags          = flags_q;
        mem_err        = mem_err_q;
        dbg_state_o    = state_q;
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized self-checking bench for alu_sequencer against a transaction-level reference model.
// Define ALU_SEQ_WATCHDOG_EN to build and check the watchdog variant with a short timeout.
module tb_alu_sequencer;

    localparam int TB_TIMEOUT = 4;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       instr_valid;
    logic [8:0] instr;
    logic       instr_ready;
    logic [2:0] rf_addr_a, rf_addr_b, rf_wr_addr, ALU_op_code;
    logic       rf_wr_en, wb_sel, Data_signifier, SC_IN;
    logic [1:0] Data_op_code;
    logic       ZERO, BEVEN, PARITY, EQUAL, SC_OUT;
    logic       mem_req, mem_we, mem_ack, busy, mem_err;
    logic [4:0] flags;
    logic [1:0] dbg_state;

    alu_sequencer #(.MEM_TIMEOUT(TB_TIMEOUT)) dut (
        .Clk(Clk), .Reset(Reset), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b),
        .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .wb_sel(wb_sel),
        .ALU_op_code(ALU_op_code), .Data_op_code(Data_op_code),
        .Data_signifier(Data_signifier), .SC_IN(SC_IN), .ZERO(ZERO), .BEVEN(BEVEN),
        .PARITY(PARITY), .EQUAL(EQUAL), .SC_OUT(SC_OUT), .mem_req(mem_req),
        .mem_we(mem_we), .mem_ack(mem_ack), .flags(flags), .busy(busy),
        .mem_err(mem_err), .dbg_state_o(dbg_state)
    );

    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [4:0] exp_flags;
    logic       exp_mem_err;
    logic [3:0] exp_q[$];   // expected register writes {wb_sel, addr}, in order

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_status(input logic [4:0] st);
        {SC_OUT, ZERO, BEVEN, PARITY, EQUAL} = st;
    endtask

    // Every register write the DUT makes must match the next one the model predicted.
    always @(negedge Clk) begin
        if (rf_wr_en === 1'b1) begin
            if (exp_q.size() == 0) check_eq("wr_unexpected", 32'(rf_wr_en), 32'd0);
            else check_eq("wr_event", 32'({wb_sel, rf_wr_addr}), 32'(exp_q.pop_front()));
        end
    end

    task automatic do_reset();
        @(posedge Clk); #1;
        Reset = 1'b1; instr_valid = 1'b0; mem_ack = 1'b0;
        @(posedge Clk); #1;
        Reset = 1'b0;
        exp_flags = '0;
        exp_mem_err = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_ready"}, 32'(instr_ready), 32'd1);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_flags"}, 32'(flags), 32'(exp_flags));
        check_eq({tag, "_scin"}, 32'(SC_IN), 32'(exp_flags[4]));
        check_eq({tag, "_memerr"}, 32'(mem_err), 32'(exp_mem_err));
        check_eq({tag, "_idle_outs"}, 32'({rf_wr_en, mem_req, mem_we, wb_sel, rf_addr_a,
                 rf_addr_b, rf_wr_addr, ALU_op_code, Data_op_code, Data_signifier}), 32'd0);
    endtask

    // One instruction end to end; delay = MEM cycle on which mem_ack is given.
    task automatic run_instr(input logic [8:0] w, input logic [4:0] st, input int delay);
        logic       ds, wr, fl, is_mem, is_st, abort;
        logic [2:0] rd, rs, aop;
        logic [1:0] dop;
        int         n_mem;
        ds = w[8];
        rs = w[2:0];
        if (ds) begin
            dop = w[7:6]; aop = 3'd0; rd = w[5:3];
            wr = (dop <= 2'd1); fl = (dop == 2'd1); is_mem = (dop >= 2'd2); is_st = (dop == 2'd3);
        end else begin
            aop = w[7:5]; dop = 2'd0; rd = {1'b0, w[4:3]};
            wr = (aop != 3'd4); fl = 1'b1; is_mem = 1'b0; is_st = 1'b0;
        end

        @(posedge Clk); #1;
        instr_valid = 1'b1; instr = w; set_status(st);
        mem_ack = 1'($urandom_range(0, 1));
        @(negedge Clk);
        check_idle("pre");
        @(posedge Clk); #1;
        instr_valid = 1'($urandom_range(0, 1));
        instr = 9'($urandom_range(0, 511));
        mem_ack = 1'($urandom_range(0, 1));
        if (wr && !is_mem) exp_q.push_back({1'b0, rd});
        @(negedge Clk);
        check_eq("exec_busy", 32'(busy), 32'd1);
        check_eq("exec_ready", 32'(instr_ready), 32'd0);
        check_eq("exec_fields", 32'({ds, aop, dop, rd, rs}),
                 32'({Data_signifier, ALU_op_code, Data_op_code, rf_addr_a, rf_addr_b}));
        check_eq("exec_wr_en", 32'(rf_wr_en), 32'(wr && !is_mem));
        if (wr && !is_mem) check_eq("exec_wr_addr", 32'(rf_wr_addr), 32'(rd));
        check_eq("exec_mem", 32'({mem_req, mem_we, wb_sel}), 32'd0);
        check_eq("exec_scin", 32'(SC_IN), 32'(exp_flags[4]));
        @(posedge Clk);
        if (fl) exp_flags = st;
        #1;
        if (is_mem) begin
            n_mem = delay;
            abort = 1'b0;
`ifdef ALU_SEQ_WATCHDOG_EN
            if (delay > TB_TIMEOUT) begin
                n_mem = TB_TIMEOUT;
                abort = 1'b1;
            end
`endif
            if (!is_st && !abort) exp_q.push_back({1'b1, rd});
            for (int k = 1; k <= n_mem; k++) begin
                mem_ack = (k == delay);
                instr_valid = 1'($urandom_range(0, 1));
                set_status(5'($urandom_range(0, 31)));
                @(negedge Clk);
                check_eq("mem_req", 32'(mem_req), 32'd1);
                check_eq("mem_we", 32'(mem_we), 32'(is_st));
                check_eq("mem_wr", 32'({rf_wr_en, wb_sel}), 32'({2{!is_st && k == delay}}));
                check_eq("mem_addrs", 32'({rf_addr_a, rf_addr_b}), 32'({rd, rs}));
                check_eq("mem_ready", 32'(instr_ready), 32'd0);
                @(posedge Clk); #1;
            end
            if (abort) exp_mem_err = 1'b1;
        end
        instr_valid = 1'b0;
        mem_ack = 1'b0;
        set_status(5'($urandom_range(0, 31)));
        @(negedge Clk);
        check_idle("post");
    endtask

    initial begin
        Reset = 1'b1; instr_valid = 1'b0; instr = '0; mem_ack = 1'b0;
        set_status(5'd0);
        exp_flags = '0; exp_mem_err = 1'b0;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        @(negedge Clk);
        check_idle("reset");

        // Directed sequence: ADD R1,R2; CMP equal; MOVE; LOAD/STORE.
        run_instr(9'b0_000_01_010, 5'b01000, 1);
        run_instr(9'b0_100_10_001, 5'b10101, 1);
        run_instr(9'b1_00_011_100, 5'b00010, 1);
        run_instr(9'b1_01_110_001, 5'b11010, 1);
        run_instr(9'b1_10_101_011, 5'b11111, 4);
        run_instr(9'b1_11_010_110, 5'b00000, 1);

        // Reset in the 2nd MEM cycle of a LOAD; a late ack must be ignored.
        run_instr(9'b0_111_11_111, 5'b11111, 1);
        @(posedge Clk); #1;
        instr_valid = 1'b1; instr = 9'b1_10_101_011;
        @(posedge Clk); #1;
        instr_valid = 1'b0;
        @(posedge Clk); #1;
        mem_ack = 1'b0;
        @(posedge Clk); #1;
        Reset = 1'b1;
        @(negedge Clk);
        check_eq("rst_mem_req_before", 32'(mem_req), 32'd1);
        @(posedge Clk); #1;
        Reset = 1'b0; mem_ack = 1'b1;
        exp_flags = '0; exp_mem_err = 1'b0;
        @(negedge Clk);
        check_idle("rst_mid_mem");
        @(posedge Clk); #1;
        mem_ack = 1'b0;
        @(negedge Clk);
        check_idle("rst_late_ack");

`ifdef ALU_SEQ_WATCHDOG_EN
        run_instr(9'b1_10_001_010, 5'b00001, 10);
        run_instr(9'b0_001_01_001, 5'b00110, 1);
        check_eq("wd_err_sticky", 32'(mem_err), 32'd1);
        do_reset();
        @(negedge Clk);
        check_eq("wd_err_cleared", 32'(mem_err), 32'd0);
`endif

        for (int i = 0; i < 250; i++) begin
            int d;
            d = ($urandom_range(0, 15) == 0) ? 20 : $urandom_range(1, 6);
            run_instr(9'($urandom_range(0, 511)), 5'($urandom_range(0, 31)), d);
            if ($urandom_range(0, 40) == 0) do_reset();
        end

        @(negedge Clk);
        check_eq("wr_queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
